// File: rtl/nfcm_arbiter_if.sv
// ============================================================================
// Module  : nfcm_arbiter_if
// Brief   : Requester-side and flash-controller-side bundle of nfcm_arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface nfcm_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_cmd;
  logic [16*NREQ-1:0] req_rwa;
  logic [NREQ-1:0]    rsp_valid;
  logic [4:0]         rsp_status;
  logic               fc_start;
  logic [2:0]         fc_cmd;
  logic [15:0]        fc_rwa;
  logic               fc_done;
  logic               perr;
  logic               eerr;
  logic               rerr;
  logic               nf_rst;
  logic               busy;
  logic [GW-1:0]      grant_id;

  modport slave (
    input  req_valid, req_cmd, req_rwa, fc_done, perr, eerr, rerr,
    output req_ready, rsp_valid, rsp_status, fc_start, fc_cmd, fc_rwa,
           nf_rst, busy, grant_id
  );

  modport master (
    output req_valid, req_cmd, req_rwa, fc_done, perr, eerr, rerr,
    input  req_ready, rsp_valid, rsp_status, fc_start, fc_cmd, fc_rwa,
           nf_rst, busy, grant_id
  );
endinterface

`default_nettype wire

// File: rtl/nfcm_arbiter.sv
// ============================================================================
// Module  : nfcm_arbiter
// Brief   : Round-robin command arbiter/sequencer with timeout recovery in
//           front of the NAND flash controller command port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module nfcm_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 20,
  parameter int RST_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  nfcm_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RECOVER   = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_last;
  logic [GW-1:0]    r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_status;
  logic [NREQ-1:0]  r_rsp_valid;
  logic             r_fc_start;
  logic [2:0]       r_fc_cmd;
  logic [15:0]      r_fc_rwa;
  logic             r_nf_rst;
  logic             r_busy;

  logic             w_hit;
  logic [GW-1:0]    w_sel;
  logic [GW-1:0]    w_idx;
  logic [2:0]       w_cmd;
  logic [15:0]      w_rwa;
  logic             w_legal;
  logic [NREQ-1:0]  w_onehot;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return GW'(s);
  endfunction

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = wrap_idx(r_last, k);
      if (!w_hit && bus.req_valid[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
    w_cmd = '0;
    w_rwa = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == GW'(i)) begin
        w_cmd = bus.req_cmd[3*i +: 3];
        w_rwa = bus.req_rwa[16*i +: 16];
      end
    end
  end

  assign w_legal  = (w_cmd >= 3'b011);
  assign w_onehot = NREQ'(1) << w_sel;

  // Accept is decided in the IDLE cycle itself; gated by rst_n so reset blanks it at once.
  assign bus.req_ready  = (rst_n && r_state == IDLE && w_hit) ? w_onehot : '0;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_status;
  assign bus.fc_start   = r_fc_start;
  assign bus.fc_cmd     = r_fc_cmd;
  assign bus.fc_rwa     = r_fc_rwa;
  assign bus.nf_rst     = r_nf_rst;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= GW'(NREQ - 1);
      r_grant     <= '0;
      r_cnt       <= '0;
      r_status    <= '0;
      r_rsp_valid <= '0;
      r_fc_start  <= 1'b0;
      r_fc_cmd    <= '0;
      r_fc_rwa    <= '0;
      r_nf_rst    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_last  <= w_sel;
            r_grant <= w_sel;
            r_busy  <= 1'b1;
            if (w_legal) begin
              r_fc_cmd   <= w_cmd;
              r_fc_rwa   <= w_rwa;
              r_fc_start <= 1'b1;
              r_status   <= '0;
              r_state    <= ISSUE;
            end else begin
              r_status    <= 5'b10000;
              r_rsp_valid <= w_onehot;
              r_state     <= RESP;
            end
          end
        end
        ISSUE: begin
          r_fc_start <= 1'b0;
          r_cnt      <= '0;
          r_state    <= WAIT_CLR;
        end
        WAIT_CLR: begin
          // A done left over from the previous operation must drop first.
          if (!bus.fc_done) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= WAIT_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_status <= 5'b01000;
            r_nf_rst <= 1'b1;
            r_cnt    <= '0;
            r_state  <= RECOVER;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.fc_done) begin
            r_status    <= {2'b00, bus.rerr, bus.eerr, bus.perr};
            r_rsp_valid <= NREQ'(1) << r_grant;
            r_state     <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_status <= 5'b01000;
            r_nf_rst <= 1'b1;
            r_cnt    <= '0;
            r_state  <= RECOVER;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RECOVER: begin
          if (r_cnt == CNT_W'(RST_CYC - 1)) begin
            r_nf_rst    <= 1'b0;
            r_rsp_valid <= NREQ'(1) << r_grant;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_nfcm_arbiter.sv
// ============================================================================
// Module  : tb_nfcm_arbiter
// Brief   : Directed, table-driven bench for nfcm_arbiter with a flash model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nfcm_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nfcm_arbiter_if #(.NREQ(NREQ)) bus ();

  nfcm_arbiter #(
    .NREQ(NREQ), .TIMEOUT(16), .CNT_W(20), .RST_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [3:0]  valid;
    logic        keep;
    logic [11:0] cmd;
    logic [63:0] rwa;
    int          clr;
    int          rise;
    logic [2:0]  errs;
    logic [3:0]  exp_ready;
    int          exp_lat;
    logic [4:0]  exp_status;
    int          exp_start;
    logic [2:0]  exp_cmd;
    logic [15:0] exp_rwa;
    int          exp_nf;
  } vec_t;

  vec_t tbl[12];
  vec_t post;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Entered and left on a falling edge of an IDLE cycle.
  task automatic run_op(input vec_t v);
    int start_n = 0, start_c = -1, rsp_c = -1, nf_n = 0, extra = 0;
    logic [2:0]  g_cmd = '0;
    logic [15:0] g_rwa = '0;
    logic [3:0]  g_rsp = '0;
    logic [4:0]  g_st = '0;
    logic [1:0]  g_id = '0;
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    bus.req_valid = v.valid;
    bus.req_cmd   = v.cmd;
    bus.req_rwa   = v.rwa;
    #1;
    check("accept", {60'd0, bus.req_ready}, {60'd0, v.exp_ready});
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) g_id = bus.grant_id;
      if (bus.fc_start) begin
        start_n++;
        start_c = c;
        g_cmd = bus.fc_cmd;
        g_rwa = bus.fc_rwa;
      end
      if (bus.nf_rst) nf_n++;
      if (bus.req_ready != 4'b0000) extra++;
      if (!v.keep && c == 1) bus.req_valid = '0;
      if (bus.rsp_valid != 4'b0000) begin
        rsp_c = c;
        g_rsp = bus.rsp_valid;
        g_st  = bus.rsp_status;
        break;
      end
      if (v.rise > 0 && c - 1 >= v.rise) begin
        bus.fc_done = 1'b1;
        {bus.rerr, bus.eerr, bus.perr} = v.errs;
      end else if (c - 1 >= v.clr) begin
        bus.fc_done = 1'b0;
      end
    end
    @(negedge clk);
    check("grant_id", 64'(g_id), 64'(onehot_idx(v.exp_ready)));
    check("start_count", 64'(start_n), 64'(v.exp_start));
    if (v.exp_start == 1) begin
      check("start_cycle", 64'(start_c), 64'd1);
      check("fc_cmd_rwa", {45'd0, g_cmd, g_rwa}, {45'd0, v.exp_cmd, v.exp_rwa});
    end
    check("rsp_cycle", 64'(rsp_c), 64'(v.exp_lat));
    check("rsp_valid", {60'd0, g_rsp}, {60'd0, v.exp_ready});
    check("rsp_status", {59'd0, g_st}, {59'd0, v.exp_status});
    check("nf_rst_cycles", 64'(nf_n), 64'(v.exp_nf));
    check("ready_while_busy", 64'(extra), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0001, 1'b0, 12'h004, 64'h1234, 1, 11, 3'b001, 4'b0001, 13, 5'b00001, 1, 3'b100, 16'h1234, 0};
    tbl[1]  = '{4'b0100, 1'b0, 12'h040, 64'h0, 99, 0, 3'b000, 4'b0100, 1, 5'b10000, 0, 3'b000, 16'h0000, 0};
    tbl[2]  = '{4'b0010, 1'b0, 12'h018, 64'hBEEF_0000, 3, 6, 3'b000, 4'b0010, 8, 5'b00000, 1, 3'b011, 16'hBEEF, 0};
    tbl[3]  = '{4'b1000, 1'b0, 12'hA00, 64'h0F0F_0000_0000_0000, 1, 0, 3'b000, 4'b1000, 26, 5'b01000, 1, 3'b101, 16'h0F0F, 8};
    tbl[4]  = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b000, 4'b0001, 4, 5'b00000, 1, 3'b011, 16'h0000, 0};
    tbl[5]  = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b010, 4'b0010, 4, 5'b00010, 1, 3'b101, 16'h1111, 0};
    tbl[6]  = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b100, 4'b0100, 4, 5'b00100, 1, 3'b110, 16'h2222, 0};
    tbl[7]  = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b111, 4'b1000, 4, 5'b00111, 1, 3'b111, 16'h3333, 0};
    tbl[8]  = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b001, 4'b0001, 4, 5'b00001, 1, 3'b011, 16'h0000, 0};
    tbl[9]  = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b000, 4'b0010, 4, 5'b00000, 1, 3'b101, 16'h1111, 0};
    tbl[10] = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b110, 4'b0100, 4, 5'b00110, 1, 3'b110, 16'h2222, 0};
    tbl[11] = '{4'b1111, 1'b1, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b011, 4'b1000, 4, 5'b00011, 1, 3'b111, 16'h3333, 0};
    post    = '{4'b1111, 1'b0, 12'hFAB, 64'h3333_2222_1111_0000, 1, 2, 3'b101, 4'b0001, 4, 5'b00101, 1, 3'b011, 16'h0000, 0};

    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_rwa   = '0;
    bus.fc_done   = 1'b0;
    bus.perr      = 1'b0;
    bus.eerr      = 1'b0;
    bus.rerr      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, bus.busy, bus.fc_start, bus.nf_rst, bus.rsp_valid, bus.rsp_status,
                            bus.grant_id, bus.fc_cmd, bus.fc_rwa, bus.req_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // Abandon an operation by asynchronous reset while it waits for done.
    bus.req_valid = 4'b0100;
    bus.req_cmd   = 12'h100;
    bus.req_rwa   = 64'h0;
    #1;
    check("pre_reset_accept", {60'd0, bus.req_ready}, 64'h4);
    @(negedge clk);
    bus.req_valid = '0;
    bus.fc_done   = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'd0, bus.busy, bus.fc_start, bus.nf_rst, bus.rsp_valid, bus.rsp_status,
                                  bus.grant_id, bus.fc_cmd, bus.fc_rwa, bus.req_ready}, 64'd0);
    bus.req_valid = 4'b1111;
    bus.req_cmd   = 12'hFAB;
    #1;
    check("ready_in_reset", {60'd0, bus.req_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
